lc3_control_fsm: RTL and testbench

- Multi-cycle control unit that sequences the LC-3-subset datapath through three phases: fetch, decode and execute.
- Fetches an instruction over a req/rdy memory handshake and holds it in an instruction register.
- Maintains the NZP condition codes, resolves branches, and drives register-file write enable and PC load/select strobes.
- Sits between instruction memory and the decoder/ALU/register file; the decoder consumes `ir`.

---
 rtl/lc3_control_fsm.sv | 193 +++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: multi-cycle fetch/decode/execute control unit for an
// LC-3 subset. Holds the instruction register, the NZP condition codes
// and a retired-instruction counter, and drives the memory request, the
// PC load/select and the register-file write enable.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   -> an unsupported opcode sets the sticky illegal flag and
//                parks the FSM in HALT until reset.
//   undefined -> unsupported opcodes retire as NOPs and illegal stays 0.

module lc3_control_fsm #(
  parameter logic [2:0] RESET_NZP = 3'b010,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rdy,
  input  logic [15:0]      mem_rdata,
  input  logic [15:0]      result,
  output logic             mem_req,
  output logic [15:0]      ir,
  output logic             pc_ld,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [2:0]       nzp,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DECODE  = 2'b01,
    EXECUTE = 2'b10,
    HALT    = 2'b11
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_OFF = 2'b01;
  localparam logic [1:0] SEL_REG = 2'b10;

  state_t cur_state;
  state_t next_state;

  logic [3:0] opcode;
  logic       is_alu;
  logic       is_br;
  logic       is_jmp;
  logic       is_legal;
  logic       br_taken;
  logic       fetch_done;
  logic       exec_cycle;
  logic       retire_now;
  logic [2:0] result_cc;

  assign state  = cur_state;
  assign opcode = ir[15:12];

  // Opcode classification and branch resolution against the current codes.
  always_comb begin
    is_alu   = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_NOT) || (opcode == OP_LEA);
    is_br    = (opcode == OP_BR);
    is_jmp   = (opcode == OP_JMP);
    is_legal = is_alu || is_br || is_jmp;
    br_taken = is_br && (|(ir[11:9] & nzp));
  end

  // Condition codes derived from the result bus; exactly one bit is set.
  always_comb begin
    result_cc = 3'b000;
    if (result[15]) begin
      result_cc = 3'b100;
    end else if (result == 16'h0000) begin
      result_cc = 3'b010;
    end else begin
      result_cc = 3'b001;
    end
  end

  // Qualified events used by both the register block and the strobes.
  always_comb begin
    fetch_done = (cur_state == FETCH) && mem_rdy;
    exec_cycle = (cur_state == EXECUTE);
`ifdef ILLEGAL_TRAP_EN
    retire_now = exec_cycle && is_legal;
`else
    retire_now = exec_cycle;
`endif
  end

  // State register plus the architectural registers it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= FETCH;
      ir        <= 16'h0000;
      nzp       <= RESET_NZP;
      retired   <= '0;
      illegal   <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (fetch_done) begin
        ir <= mem_rdata;
      end
      if (exec_cycle && is_alu) begin
        nzp <= result_cc;
      end
      if (retire_now) begin
        retired <= retired + 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      if (exec_cycle && !is_legal) begin
        illegal <= 1'b1;
      end
`else
      illegal <= 1'b0;
`endif
    end
  end

  // Next-state logic: fetch waits on the handshake, the rest take one cycle.
  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      FETCH: begin
        if (mem_rdy) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        next_state = EXECUTE;
      end
      EXECUTE: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = is_legal ? FETCH : HALT;
`else
        next_state = FETCH;
`endif
      end
      HALT: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = HALT;
`else
        next_state = FETCH;
`endif
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // Output strobes; everything is held low while reset is asserted.
  always_comb begin
    mem_req = 1'b0;
    pc_ld   = 1'b0;
    pc_sel  = SEL_INC;
    reg_we  = 1'b0;
    if (!rst) begin
      unique case (cur_state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            pc_ld  = 1'b1;
            pc_sel = SEL_INC;
          end
        end
        EXECUTE: begin
          if (is_alu) begin
            reg_we = 1'b1;
          end else if (br_taken) begin
            pc_ld  = 1'b1;
            pc_sel = SEL_OFF;
          end else if (is_jmp) begin
            pc_ld  = 1'b1;
            pc_sel = SEL_REG;
          end
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed self-checking bench for lc3_control_fsm.
// Inputs change just after the falling edge and outputs are checked 1 ns
// later, so every check sits half a cycle away from the active edge.
// The counter width is reduced so that the wrap-around is reachable.

module tb_lc3_control_fsm;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst;
  logic                mem_rdy;
  logic [15:0]         mem_rdata;
  logic [15:0]         result;
  logic                mem_req;
  logic [15:0]         ir;
  logic                pc_ld;
  logic [1:0]          pc_sel;
  logic                reg_we;
  logic [2:0]          nzp;
  logic [1:0]          state;
  logic [TB_CNT_W-1:0] retired;
  logic                illegal;

  int compared;
  int mismatched;
  logic [TB_CNT_W-1:0] exp_ret;

  lc3_control_fsm #(
    .RESET_NZP (3'b010),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata),
    .result    (result),
    .mem_req   (mem_req),
    .ir        (ir),
    .pc_ld     (pc_ld),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .nzp       (nzp),
    .state     (state),
    .retired   (retired),
    .illegal   (illegal)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs after the falling edge and let outputs settle.
  task automatic applyStimulus(input logic r, input logic rdy,
                               input logic [15:0] rdata, input logic [15:0] res);
    @(negedge clk);
    rst       = r;
    mem_rdy   = rdy;
    mem_rdata = rdata;
    result    = res;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] check %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Zero-wait fetch, decode and execute of one instruction, no checks.
  task automatic runInstr(input logic [15:0] instr, input logic [15:0] res);
    applyStimulus(1'b0, 1'b1, instr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, res);
    exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_ret    = '0;
    rst        = 1'b1;
    mem_rdy    = 1'b0;
    mem_rdata  = 16'h0000;
    result     = 16'h0000;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_ir", 32'(ir), 32'h0);
    checkOutput("rst_nzp", 32'(nzp), 32'b010);
    checkOutput("rst_retired", 32'(retired), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);

    // ADD with two wait cycles, negative result.
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("f1_mem_req", 32'(mem_req), 32'd1);
    checkOutput("f1_pc_ld", 32'(pc_ld), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("f2_mem_req", 32'(mem_req), 32'd1);
    checkOutput("f2_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h1042, 16'h0000);
    checkOutput("f3_mem_req", 32'(mem_req), 32'd1);
    checkOutput("f3_pc_ld", 32'(pc_ld), 32'd1);
    checkOutput("f3_pc_sel", 32'(pc_sel), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    checkOutput("dec_state", 32'(state), 32'd1);
    checkOutput("dec_ir", 32'(ir), 32'h1042);
    checkOutput("dec_mem_req", 32'(mem_req), 32'd0);
    checkOutput("dec_pc_ld", 32'(pc_ld), 32'd0);
    checkOutput("dec_reg_we", 32'(reg_we), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h7777, 16'hFFFF);
    checkOutput("ex_state", 32'(state), 32'd2);
    checkOutput("ex_reg_we", 32'(reg_we), 32'd1);
    checkOutput("ex_pc_ld", 32'(pc_ld), 32'd0);
    exp_ret = exp_ret + 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("add_nzp_neg", 32'(nzp), 32'b100);
    checkOutput("add_retired", 32'(retired), 32'(exp_ret));
    checkOutput("add_ir_kept", 32'(ir), 32'h1042);
    checkOutput("back_fetch", 32'(state), 32'd0);

    // ADD with zero result, then branches on z and n.
    runInstr(16'h1042, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0405, 16'h0000);
    checkOutput("add_nzp_zero", 32'(nzp), 32'b010);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h8000);
    checkOutput("brz_pc_ld", 32'(pc_ld), 32'd1);
    checkOutput("brz_pc_sel", 32'(pc_sel), 32'd1);
    checkOutput("brz_reg_we", 32'(reg_we), 32'd0);
    exp_ret = exp_ret + 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0805, 16'h0000);
    checkOutput("brz_nzp_kept", 32'(nzp), 32'b010);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h8000);
    checkOutput("brn_pc_ld", 32'(pc_ld), 32'd0);
    checkOutput("brn_pc_sel", 32'(pc_sel), 32'd0);
    exp_ret = exp_ret + 1'b1;

    // BR with no condition bits is a NOP; all three bits always branch.
    applyStimulus(1'b0, 1'b1, 16'h0005, 16'h0000);
    checkOutput("brn_nzp_kept", 32'(nzp), 32'b010);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("brnop_pc_ld", 32'(pc_ld), 32'd0);
    exp_ret = exp_ret + 1'b1;
    runInstr(16'h1042, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h0E05, 16'h0000);
    checkOutput("pos_nzp", 32'(nzp), 32'b001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("brnzp_pc_ld", 32'(pc_ld), 32'd1);
    checkOutput("brnzp_pc_sel", 32'(pc_sel), 32'd1);
    exp_ret = exp_ret + 1'b1;

    // JMP: three cycles with zero wait, PC from register.
    applyStimulus(1'b0, 1'b1, 16'hC1C0, 16'h0000);
    checkOutput("jmp_fetch_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("jmp_dec_state", 32'(state), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("jmp_pc_ld", 32'(pc_ld), 32'd1);
    checkOutput("jmp_pc_sel", 32'(pc_sel), 32'd2);
    checkOutput("jmp_reg_we", 32'(reg_we), 32'd0);
    exp_ret = exp_ret + 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("jmp_state", 32'(state), 32'd0);
    checkOutput("jmp_nzp_kept", 32'(nzp), 32'b001);
    checkOutput("jmp_retired", 32'(retired), 32'(exp_ret));

    // Reset during a fetch wait with a coincident mem_rdy pulse.
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'h0000);
    checkOutput("rstf_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rstf_pc_ld", 32'(pc_ld), 32'd0);
    exp_ret = '0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rstf_ir", 32'(ir), 32'h0);
    checkOutput("rstf_state", 32'(state), 32'd0);
    checkOutput("rstf_mem_req2", 32'(mem_req), 32'd1);
    checkOutput("rstf_pc_ld2", 32'(pc_ld), 32'd0);

    // Reset during EXECUTE suppresses strobes and register updates.
    runInstr(16'h1042, 16'h0001);
    applyStimulus(1'b0, 1'b1, 16'h1042, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'hFFFF);
    checkOutput("rstx_reg_we", 32'(reg_we), 32'd0);
    checkOutput("rstx_pc_ld", 32'(pc_ld), 32'd0);
    exp_ret = '0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("rstx_nzp", 32'(nzp), 32'b010);
    checkOutput("rstx_retired", 32'(retired), 32'd0);
    checkOutput("rstx_state", 32'(state), 32'd0);

    // Unsupported opcode.
    applyStimulus(1'b0, 1'b1, 16'hF025, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF);
    checkOutput("ill_reg_we", 32'(reg_we), 32'd0);
    checkOutput("ill_pc_ld", 32'(pc_ld), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h1042, 16'h0000);
    checkOutput("ill_nzp_kept", 32'(nzp), 32'b010);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill_state", 32'(state), 32'd3);
    checkOutput("ill_flag", 32'(illegal), 32'd1);
    checkOutput("ill_mem_req", 32'(mem_req), 32'd0);
    checkOutput("ill_retired", 32'(retired), 32'(exp_ret));
    applyStimulus(1'b0, 1'b1, 16'h1042, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h1042, 16'h0000);
    checkOutput("halt_state", 32'(state), 32'd3);
    checkOutput("halt_mem_req", 32'(mem_req), 32'd0);
    checkOutput("halt_pc_ld", 32'(pc_ld), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    exp_ret = '0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("halt_rst_state", 32'(state), 32'd0);
    checkOutput("halt_rst_flag", 32'(illegal), 32'd0);
`else
    exp_ret = exp_ret + 1'b1;
    checkOutput("ill_state", 32'(state), 32'd0);
    checkOutput("ill_flag", 32'(illegal), 32'd0);
    checkOutput("ill_mem_req", 32'(mem_req), 32'd1);
    checkOutput("ill_retired", 32'(retired), 32'(exp_ret));
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    exp_ret = '0;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
`endif

    // Counter wrap: 2^TB_CNT_W NOT instructions with a positive result.
    for (int i = 0; i < (1 << TB_CNT_W) - 1; i++) begin
      runInstr(16'h903F, 16'h0001);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("wrap_max", 32'(retired), 32'((1 << TB_CNT_W) - 1));
    runInstr(16'h903F, 16'h0001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("wrap_zero", 32'(retired), 32'd0);
    checkOutput("wrap_model", 32'(retired), 32'(exp_ret));
    checkOutput("wrap_nzp", 32'(nzp), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
